branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 140 ++++++++++++++
 tb/tb_branch_predictor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational; updates, invalidation and performance counters are registered.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             update_valid,
  input  logic [XLEN-1:0]  update_pc,
  input  logic             update_taken,
  input  logic [XLEN-1:0]  update_target,
  input  logic             update_is_jump,
  input  logic             update_mispredict,
  input  logic             invalidate,
  output logic [CNT_W-1:0] perf_updates,
  output logic [CNT_W-1:0] perf_mispredicts
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [CNT_W-1:0]   perf_upd_q, perf_upd_d;
  logic [CNT_W-1:0]   perf_mis_q, perf_mis_d;

  logic [IDX-1:0]   lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic [IDX-1:0]   upd_idx_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic             upd_hit_s;
  logic             wr_en_s;
  logic [XLEN-1:0]  wr_target_s;
  logic [1:0]       wr_ctr_s;
  logic             unused_pc_bits_s;

  assign lk_idx_s  = lookup_pc[IDX+1:2];
  assign lk_tag_s  = lookup_pc[XLEN-1:IDX+2];
  assign upd_idx_s = update_pc[IDX+1:2];
  assign upd_tag_s = update_pc[XLEN-1:IDX+2];
  assign upd_hit_s = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
  assign unused_pc_bits_s = ^update_pc[1:0];

  // Combinational lookup against the pre-update table state.
  always_comb begin
    pred_hit    = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
    pred_taken  = pred_hit && ctr_q[lk_idx_s][1];
    if (pred_taken) begin
      pred_target = target_q[lk_idx_s];
    end else begin
      pred_target = lookup_pc + XLEN'(4);
    end
  end

  // Entry write decision: jumps force allocation, hits train, taken misses allocate.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_target_s = target_q[upd_idx_s];
    wr_ctr_s    = ctr_q[upd_idx_s];
    if (!update_valid) begin
      wr_en_s = 1'b0;
    end else if (update_is_jump) begin
      wr_en_s     = 1'b1;
      wr_target_s = update_target;
      wr_ctr_s    = 2'b11;
    end else if (upd_hit_s) begin
      wr_en_s = 1'b1;
      if (update_taken) begin
        wr_target_s = update_target;
        wr_ctr_s    = (ctr_q[upd_idx_s] == 2'b11) ? 2'b11 : ctr_q[upd_idx_s] + 2'b01;
      end else begin
        wr_ctr_s    = (ctr_q[upd_idx_s] == 2'b00) ? 2'b00 : ctr_q[upd_idx_s] - 2'b01;
      end
    end else if (update_taken) begin
      wr_en_s     = 1'b1;
      wr_target_s = update_target;
      wr_ctr_s    = 2'b10;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Saturating performance counters; counted even when invalidate drops the write.
  always_comb begin
    perf_upd_d = perf_upd_q;
    perf_mis_d = perf_mis_q;
    if (update_valid) begin
      if (perf_upd_q != {CNT_W{1'b1}}) begin
        perf_upd_d = perf_upd_q + CNT_W'(1);
      end else begin
        perf_upd_d = perf_upd_q;
      end
      if (update_mispredict && (perf_mis_q != {CNT_W{1'b1}})) begin
        perf_mis_d = perf_mis_q + CNT_W'(1);
      end else begin
        perf_mis_d = perf_mis_q;
      end
    end else begin
      perf_upd_d = perf_upd_q;
      perf_mis_d = perf_mis_q;
    end
  end

  // Table and counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      perf_upd_q <= '0;
      perf_mis_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      perf_upd_q <= perf_upd_d;
      perf_mis_q <= perf_mis_d;
      if (invalidate) begin
        valid_q <= '0;
      end else if (wr_en_s) begin
        valid_q[upd_idx_s]  <= 1'b1;
        tag_q[upd_idx_s]    <= upd_tag_s;
        target_q[upd_idx_s] <= wr_target_s;
        ctr_q[upd_idx_s]    <= wr_ctr_s;
      end
    end
  end

  assign perf_updates     = perf_upd_q;
  assign perf_mispredicts = perf_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (ENTRIES=16, CNT_W=4 so saturation is reachable).
module tb_branch_predictor;

  localparam int XLEN  = 32;
  localparam int ENT   = 16;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [XLEN-1:0]  lookup_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             update_valid;
  logic [XLEN-1:0]  update_pc;
  logic             update_taken;
  logic [XLEN-1:0]  update_target;
  logic             update_is_jump;
  logic             update_mispredict;
  logic             invalidate;
  logic [CNT_W-1:0] perf_updates;
  logic [CNT_W-1:0] perf_mispredicts;

  int checks;
  int failures;

  logic [XLEN+1:0] exp_q [$];
  string           tag_q [$];

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_is_jump(update_is_jump),
    .update_mispredict(update_mispredict), .invalidate(invalidate),
    .perf_updates(perf_updates), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare against the live lookup outputs.
  task automatic pop_compare();
    logic [XLEN+1:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_val({t, ".hit"},    64'(pred_hit),    64'(e[XLEN+1]));
    check_val({t, ".taken"},  64'(pred_taken),  64'(e[XLEN]));
    check_val({t, ".target"}, 64'(pred_target), 64'(e[XLEN-1:0]));
  endtask

  task automatic look(input string tag, input logic [XLEN-1:0] pc,
                      input logic hit, input logic taken, input logic [XLEN-1:0] tgt);
    exp_q.push_back({hit, taken, tgt});
    tag_q.push_back(tag);
    lookup_pc = pc;
    #1;
    pop_compare();
  endtask

  task automatic upd(input logic [XLEN-1:0] pc, input logic taken, input logic [XLEN-1:0] tgt,
                     input logic jump, input logic mis, input logic inv);
    @(negedge clk);
    update_valid      = 1'b1;
    update_pc         = pc;
    update_taken      = taken;
    update_target     = tgt;
    update_is_jump    = jump;
    update_mispredict = mis;
    invalidate        = inv;
    @(negedge clk);
    update_valid      = 1'b0;
    update_mispredict = 1'b0;
    update_is_jump    = 1'b0;
    invalidate        = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    clk = 1'b0; rst_n = 1'b0; lookup_pc = '0;
    update_valid = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0;
    update_is_jump = 1'b0; update_mispredict = 1'b0; invalidate = 1'b0;

    // Reset state
    #12;
    look("rst_lookup", 32'h100, 1'b0, 1'b0, 32'h104);
    look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    check_val("rst_perf_upd", 64'(perf_updates), 64'd0);
    check_val("rst_perf_mis", 64'(perf_mispredicts), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Allocate on taken miss, no same-cycle bypass, then one not-taken
    @(negedge clk);
    update_valid = 1'b1; update_pc = 32'h100; update_taken = 1'b1; update_target = 32'h40;
    look("no_bypass", 32'h100, 1'b0, 1'b0, 32'h104);
    @(negedge clk);
    update_valid = 1'b0;
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h40);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look("weak_nt", 32'h100, 1'b1, 1'b0, 32'h104);

    // Counter saturation in both directions
    do_reset();
    for (int i = 0; i < 4; i++) upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    look("sat_t", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look("st_to_wt", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look("wt_to_wn", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look("sat_nt", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    look("sn_to_wn", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
    look("wn_to_wt", 32'h100, 1'b1, 1'b1, 32'h88);
    check_val("perf_upd_10", 64'(perf_updates), 64'd10);
    check_val("perf_mis_0", 64'(perf_mispredicts), 64'd0);

    // Aliasing: jump to 0x140 evicts 0x100; not-taken miss leaves table alone
    do_reset();
    upd(32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    upd(32'h140, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h140, 1'b1, 1'b1, 32'h400);
    upd(32'h180, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look("nt_miss_keep", 32'h140, 1'b1, 1'b1, 32'h400);
    look("nt_miss_noalloc", 32'h180, 1'b0, 1'b0, 32'h184);
    upd(32'h140, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look("jump_ctr11", 32'h140, 1'b1, 1'b1, 32'h400);

    // Invalidate overrides a simultaneous update but the update is counted
    do_reset();
    upd(32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    check_val("inv_perf_before", 64'(perf_updates), 64'd1);
    upd(32'h200, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
    look("inv_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("inv_drop", 32'h200, 1'b0, 1'b0, 32'h204);
    check_val("inv_perf_after", 64'(perf_updates), 64'd2);
    @(negedge clk);
    update_pc = 32'h200; update_taken = 1'b1; update_is_jump = 1'b1; update_mispredict = 1'b1;
    @(negedge clk);
    update_is_jump = 1'b0; update_mispredict = 1'b0;
    look("idle_ignored", 32'h200, 1'b0, 1'b0, 32'h204);
    check_val("idle_perf_upd", 64'(perf_updates), 64'd2);
    check_val("idle_perf_mis", 64'(perf_mispredicts), 64'd0);

    // Reset mid-update discards it; first edge after release accepts a new one
    @(negedge clk);
    update_valid = 1'b1; update_pc = 32'h300; update_taken = 1'b1; update_target = 32'h10;
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    update_pc = 32'h304; update_target = 32'h50;
    @(negedge clk);
    update_valid = 1'b0;
    look("rst_discard", 32'h300, 1'b0, 1'b0, 32'h304);
    look("rst_first_upd", 32'h304, 1'b1, 1'b1, 32'h50);
    check_val("rst_perf_one", 64'(perf_updates), 64'd1);

    // Perf counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) upd(32'h500, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_val("sat_perf_upd", 64'(perf_updates), 64'd15);
    check_val("sat_perf_mis", 64'(perf_mispredicts), 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
